// File: rtl/armleocpu_loadgen_pipe.sv
// Load result generator: extracts/extends the addressed byte/half/word from a raw
// memory word and queues it in a DEPTH-entry FIFO. Optional ARMLEOCPU_LOADGEN_STATS_EN adds counters.
module armleocpu_loadgen_pipe #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_offset,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_missaligned,
    output logic        out_unknowntype
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_errors
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_data [DEPTH];
    logic          r_mis  [DEPTH];
    logic          r_unk  [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_sh;
    logic [31:0]   w_res;
    logic          w_mis;
    logic          w_unk;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // in_ready looks only at the registered count, so a pop never frees a slot in the same cycle
    assign in_ready        = (r_count != CW'(DEPTH));
    assign out_valid       = (r_count != {CW{1'b0}});
    assign w_push          = in_valid & in_ready;
    assign w_pop           = out_valid & out_ready;
    assign out_data        = r_data[r_rptr];
    assign out_missaligned = r_mis[r_rptr];
    assign out_unknowntype = r_unk[r_rptr];

    // Extract, extend and classify the incoming load
    always_comb begin
        w_sh  = in_data >> {in_offset, 3'b000};
        w_res = 32'h0000_0000;
        w_mis = 1'b0;
        w_unk = 1'b0;
        case (in_type)
            3'b000: w_res = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b100: w_res = {24'h00_0000, w_sh[7:0]};
            3'b001: begin
                if (in_offset[0]) begin
                    w_mis = 1'b1;
                end else begin
                    w_res = {{16{w_sh[15]}}, w_sh[15:0]};
                end
            end
            3'b101: begin
                if (in_offset[0]) begin
                    w_mis = 1'b1;
                end else begin
                    w_res = {16'h0000, w_sh[15:0]};
                end
            end
            3'b010: begin
                if (in_offset != 2'b00) begin
                    w_mis = 1'b1;
                end else begin
                    w_res = w_sh;
                end
            end
            default: w_unk = 1'b1;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= 32'h0000_0000;
                r_mis[i]  <= 1'b0;
                r_unk[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_res;
                r_mis[r_wptr]  <= w_mis;
                r_unk[r_wptr]  <= w_unk;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ARMLEOCPU_LOADGEN_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_errors;

    assign stat_loads  = r_stat_loads;
    assign stat_errors = r_stat_errors;

    // Saturating push and error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_loads  <= 32'h0000_0000;
            r_stat_errors <= 32'h0000_0000;
        end else begin
            if (w_push && (r_stat_loads != 32'hFFFF_FFFF)) begin
                r_stat_loads <= r_stat_loads + 32'h0000_0001;
            end
            if (w_push && (w_mis || w_unk) && (r_stat_errors != 32'hFFFF_FFFF)) begin
                r_stat_errors <= r_stat_errors + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_armleocpu_loadgen_pipe.sv
// Self-checking bench for armleocpu_loadgen_pipe: directed vectors, backpressure,
// mid-stream reset and randomized traffic against a queue-based reference model.
module tb_armleocpu_loadgen_pipe;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_offset;
    logic [2:0]  in_type;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_missaligned;
    logic        out_unknowntype;
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_errors;
`endif

    int checks = 0;
    int errors = 0;

    armleocpu_loadgen_pipe #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_offset       (in_offset),
        .in_type         (in_type),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_missaligned (out_missaligned),
        .out_unknowntype (out_unknowntype)
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
        ,
        .stat_loads      (stat_loads),
        .stat_errors     (stat_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {unknown, misaligned, data} from the load rules, using plain arithmetic
    function automatic logic [33:0] ref_load(input logic [2:0] ty, input logic [1:0] off,
                                             input logic [31:0] d);
        int unsigned nbytes;
        logic        sgn;
        logic [31:0] w;
        logic [31:0] v;
        case (ty)
            3'd0:    begin nbytes = 1; sgn = 1'b1; end
            3'd1:    begin nbytes = 2; sgn = 1'b1; end
            3'd2:    begin nbytes = 4; sgn = 1'b0; end
            3'd4:    begin nbytes = 1; sgn = 1'b0; end
            3'd5:    begin nbytes = 2; sgn = 1'b0; end
            default: return {1'b1, 1'b0, 32'h0};
        endcase
        if ((off % nbytes) != 0) return {1'b0, 1'b1, 32'h0};
        w = d >> (8 * off);
        if (nbytes == 4) begin
            v = w;
        end else begin
            v = w % (32'd1 << (8 * nbytes));
            if (sgn && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
        end
        return {2'b00, v};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_type = 3'b010; in_offset = 2'b00; in_data = 32'hABCD_1234; out_ready = 1'b0;
        do_reset();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        checks++;
        if ({out_unknowntype, out_missaligned, out_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%b/%b expected 0/0/0", out_data, out_missaligned, out_unknowntype);
        end
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
        checks++;
        if (stat_loads !== 32'h0 || stat_errors !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_loads, stat_errors);
        end
`endif
    endtask

    task automatic test_extract();
        logic [2:0]  tys  [12] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011,
                                   3'b010, 3'b001, 3'b101, 3'b110, 3'b111, 3'b000};
        logic [1:0]  offs [12] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0,
                                   2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] dats [12] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234,
                                   32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h5555_5555, 32'h5555_5555, 32'h1234_567F};
        logic [33:0] exps [12] = '{{2'b00, 32'hFFFF_FF80}, {2'b00, 32'h0000_0080},
                                   {2'b00, 32'hFFFF_8001}, {2'b00, 32'h0000_8001},
                                   {2'b01, 32'h0}, {2'b10, 32'h0},
                                   {2'b00, 32'hDEAD_BEEF}, {2'b01, 32'h0},
                                   {2'b01, 32'h0}, {2'b10, 32'h0},
                                   {2'b10, 32'h0}, {2'b00, 32'h0000_007F}};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_type = tys[i]; in_offset = offs[i]; in_data = dats[i];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || {out_unknowntype, out_missaligned, out_data} !== exps[i]) begin
                errors++;
                $display("FAIL extract[%0d]: got v=%b %b/%b/%h expected v=1 %b/%b/%h", i, out_valid,
                         out_unknowntype, out_missaligned, out_data, exps[i][33], exps[i][32], exps[i][31:0]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL extract_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'b010; in_offset = 2'b00; in_data = 32'hAAAA_0001;
        @(posedge clk); @(negedge clk);
        in_data = 32'hBBBB_0002;
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bp_one: in_ready=%b out_data=%h expected 1/aaaa0001", in_ready, out_data);
        end
        @(posedge clk); @(negedge clk);
        in_data = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin
                errors++;
                $display("FAIL bp_full[%0d]: in_ready=%b out_valid=%b out_data=%h expected 0/1/aaaa0001",
                         i, in_ready, out_valid, out_data);
            end
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL bp_pop_full: in_ready=%b out_valid=%b out_data=%h expected 1/1/bbbb0002",
                     in_ready, out_valid, out_data);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL bp_third: out_valid=%b out_data=%h expected 1/cccc0003", out_valid, out_data);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b expected 0", out_valid);
        end
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
        checks++;
        if (stat_loads !== 32'd3 || stat_errors !== 32'd0) begin
            errors++;
            $display("FAIL bp_stats: got %0d/%0d expected 3/0", stat_loads, stat_errors);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'b011; in_offset = 2'b00; in_data = 32'h1357_9BDF;
        @(posedge clk); @(negedge clk);
        in_type = 3'b010;
        checks++;
        if (out_valid !== 1'b1 || out_unknowntype !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: out_valid=%b unk=%b expected 1/1", out_valid, out_unknowntype);
        end
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_unknowntype !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b out_data=%h unk=%b expected 0/1/0/0",
                     out_valid, in_ready, out_data, out_unknowntype);
        end
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
        checks++;
        if (stat_loads !== 32'h0 || stat_errors !== 32'h0) begin
            errors++;
            $display("FAIL mid_stats: got %0d/%0d expected 0/0", stat_loads, stat_errors);
        end
`endif
    endtask

    task automatic test_random();
        logic [33:0] q[$];
        logic [33:0] ent;
        int unsigned exp_loads = 0;
        int unsigned exp_errs  = 0;
        bit          push;
        bit          pop;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_type   = 3'($urandom_range(0, 7));
            in_offset = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_hs[%0d]: out_valid=%b in_ready=%b expected %b/%b", cyc,
                         out_valid, in_ready, q.size() != 0, q.size() < DEPTH);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_unknowntype, out_missaligned, out_data} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %b/%b/%h expected %b/%b/%h", cyc, out_unknowntype,
                             out_missaligned, out_data, q[0][33], q[0][32], q[0][31:0]);
                end
            end
`ifdef ARMLEOCPU_LOADGEN_STATS_EN
            checks++;
            if (stat_loads !== exp_loads || stat_errors !== exp_errs) begin
                errors++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d expected %0d/%0d", cyc,
                         stat_loads, stat_errors, exp_loads, exp_errs);
            end
`endif
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() != 0);
            ent  = ref_load(in_type, in_offset, in_data);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ent);
                exp_loads++;
                if (ent[33] || ent[32]) exp_errs++;
            end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_offset = 2'b00; in_type = 3'b000; in_data = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_extract();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
